// File: rtl/shift_unit_seq_if.sv
// Operand/result bundle between the ALU controller (master) and shift_unit_seq (slave).
interface shift_unit_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_FUN;
    logic             Shift_Enable;
    logic [WIDTH-1:0] Shift_OUT;
    logic             Shift_Flag;
    logic             Carry_OUT;
    logic             Shift_Err;
    logic             Busy;

    modport master (
        output A, B, ALU_FUN, Shift_Enable,
        input  Shift_OUT, Shift_Flag, Carry_OUT, Shift_Err, Busy
    );

    modport slave (
        input  A, B, ALU_FUN, Shift_Enable,
        output Shift_OUT, Shift_Flag, Carry_OUT, Shift_Err, Busy
    );
endinterface

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter/rotator (SRL/SLL/SRA/ROR/ROL) with start/busy/done handshake.
// Define SHIFT_UNIT_SEQ_BARREL_EN to replace the serial SHIFT loop with a one-cycle barrel shifter.
module shift_unit_seq #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = $clog2(WIDTH),
    parameter int unsigned STEP    = 1
) (
    input logic             CLK,
    input logic             RST,
    shift_unit_seq_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [2:0] ModeSrl = 3'd0;
    localparam logic [2:0] ModeSll = 3'd1;
    localparam logic [2:0] ModeSra = 3'd2;
    localparam logic [2:0] ModeRor = 3'd3;
    localparam logic [2:0] ModeRol = 3'd4;

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [2:0]       mode_q;
    logic             carry_q;

    logic [SHAMT_W-1:0] amt;
    logic [2:0]         fun;
    logic               unused_bits;

    assign amt         = bus.B[SHAMT_W-1:0];
    assign fun         = bus.ALU_FUN[2:0];
    assign unused_bits = ^{bus.B[WIDTH-1:SHAMT_W], bus.ALU_FUN[3]};

    // One-position step; MSB of the result is the bit that left the word.
    function automatic logic [WIDTH:0] shift1(input logic [2:0] mode, input logic [WIDTH-1:0] w);
        logic [WIDTH:0] r;
        case (mode)
            ModeSrl: r = {w[0], 1'b0, w[WIDTH-1:1]};
            ModeSll: r = {w[WIDTH-1], w[WIDTH-2:0], 1'b0};
            ModeSra: r = {w[0], w[WIDTH-1], w[WIDTH-1:1]};
            ModeRor: r = {w[0], w[0], w[WIDTH-1:1]};
            ModeRol: r = {w[WIDTH-1], w[WIDTH-2:0], w[WIDTH-1]};
            default: r = {1'b0, w};
        endcase
        return r;
    endfunction

`ifdef SHIFT_UNIT_SEQ_BARREL_EN
    logic [WIDTH-1:0] bar_work;
    logic             bar_carry;

    always_comb begin
        bar_work  = bus.A;
        bar_carry = 1'b0;
        for (int i = 0; i < int'(WIDTH) - 1; i++) begin
            if (i < int'(amt)) begin
                {bar_carry, bar_work} = shift1(fun, bar_work);
            end
        end
    end
`else
    localparam logic [SHAMT_W-1:0] StepAmt = SHAMT_W'(STEP);

    logic [SHAMT_W-1:0] rem_q;
    logic [SHAMT_W-1:0] rem_next;
    logic [WIDTH-1:0]   step_work;
    logic               step_carry;

    // Apply min(STEP, remaining) single-bit steps this cycle.
    always_comb begin
        step_work  = work_q;
        step_carry = carry_q;
        for (int i = 0; i < int'(STEP); i++) begin
            if (i < int'(rem_q)) begin
                {step_carry, step_work} = shift1(mode_q, step_work);
            end
        end
        rem_next = (rem_q > StepAmt) ? (rem_q - StepAmt) : '0;
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= StIdle;
            work_q         <= '0;
            mode_q         <= '0;
            carry_q        <= 1'b0;
`ifndef SHIFT_UNIT_SEQ_BARREL_EN
            rem_q          <= '0;
`endif
            bus.Shift_OUT  <= '0;
            bus.Shift_Flag <= 1'b0;
            bus.Carry_OUT  <= 1'b0;
            bus.Shift_Err  <= 1'b0;
            bus.Busy       <= 1'b0;
        end else begin
            bus.Shift_Flag <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.Shift_Enable) begin
                        mode_q   <= fun;
                        bus.Busy <= 1'b1;
`ifdef SHIFT_UNIT_SEQ_BARREL_EN
                        work_q   <= bar_work;
                        carry_q  <= bar_carry;
                        state_q  <= StDone;
`else
                        work_q   <= bus.A;
                        carry_q  <= 1'b0;
                        rem_q    <= amt;
                        if (amt == '0 || fun > ModeRol) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StShift;
                        end
`endif
                    end
                end
`ifndef SHIFT_UNIT_SEQ_BARREL_EN
                StShift: begin
                    work_q  <= step_work;
                    carry_q <= step_carry;
                    rem_q   <= rem_next;
                    if (rem_next == '0) begin
                        state_q <= StDone;
                    end
                end
`endif
                StDone: begin
                    // Illegal modes report a zero result and no carry.
                    bus.Shift_OUT  <= (mode_q > ModeRol) ? '0 : work_q;
                    bus.Carry_OUT  <= (mode_q > ModeRol) ? 1'b0 : carry_q;
                    bus.Shift_Err  <= (mode_q > ModeRol);
                    bus.Shift_Flag <= 1'b1;
                    bus.Busy       <= 1'b0;
                    state_q        <= StIdle;
                end
                default: begin
                    state_q  <= StIdle;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_seq.sv
// Scoreboard bench for shift_unit_seq: STEP=1 and STEP=4 instances, expectations from a
// whole-amount reference model, latency checked per op.
module tb_shift_unit_seq;

    localparam int unsigned W = 16;

    typedef struct {
        logic [15:0] out;
        logic        carry;
        logic        err;
        int          lat;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];

    logic        sel_g = 1'b0;
    logic [15:0] m_out;
    logic        m_flag, m_carry, m_err, m_busy;

    shift_unit_seq_if #(.WIDTH(W)) bus1 ();
    shift_unit_seq_if #(.WIDTH(W)) bus4 ();

    shift_unit_seq #(.WIDTH(W), .SHAMT_W(4), .STEP(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1.slave)
    );
    shift_unit_seq #(.WIDTH(W), .SHAMT_W(4), .STEP(4)) dut4 (
        .CLK(CLK), .RST(RST), .bus(bus4.slave)
    );

    always #5 CLK = ~CLK;

    assign m_out   = sel_g ? bus4.Shift_OUT  : bus1.Shift_OUT;
    assign m_flag  = sel_g ? bus4.Shift_Flag : bus1.Shift_Flag;
    assign m_carry = sel_g ? bus4.Carry_OUT  : bus1.Carry_OUT;
    assign m_err   = sel_g ? bus4.Shift_Err  : bus1.Shift_Err;
    assign m_busy  = sel_g ? bus4.Busy       : bus1.Busy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic [3:0] fun,
                         input logic [15:0] a, input logic [15:0] b);
        if (sel) begin
            bus4.Shift_Enable = en; bus4.ALU_FUN = fun; bus4.A = a; bus4.B = b;
        end else begin
            bus1.Shift_Enable = en; bus1.ALU_FUN = fun; bus1.A = a; bus1.B = b;
        end
    endtask

    function automatic exp_t model(input logic [3:0] fun, input logic [15:0] a,
                                   input logic [3:0] amt, input int step);
        exp_t e;
        int   n = int'(amt);
        e.out   = a;
        e.carry = 1'b0;
        e.err   = 1'b0;
        if (fun[2:0] > 3'd4) begin
            e.out = '0;
            e.err = 1'b1;
            e.lat = 1;
        end else begin
            e.lat = (n == 0) ? 1 : 1 + (n + step - 1) / step;
            if (n != 0) begin
                case (fun[2:0])
                    3'd0: begin e.out = a >> n; e.carry = a[n-1]; end
                    3'd1: begin e.out = a << n; e.carry = a[16-n]; end
                    3'd2: begin e.out = $signed(a) >>> n; e.carry = a[n-1]; end
                    3'd3: begin e.out = (a >> n) | (a << (16 - n)); e.carry = a[n-1]; end
                    default: begin e.out = (a << n) | (a >> (16 - n)); e.carry = a[16-n]; end
                endcase
            end
        end
`ifdef SHIFT_UNIT_SEQ_BARREL_EN
        e.lat = 1;
`endif
        return e;
    endfunction

    // pulse: hold Shift_Enable high through the first busy edge; it must be ignored.
    task automatic run_op(input bit sel, input logic [3:0] fun, input logic [15:0] a,
                          input logic [15:0] b, input bit pulse);
        exp_t e;
        int   cyc;
        int   extra;
        bit   seen;
        sb.push_back(model(fun, a, b[3:0], sel ? 4 : 1));
        @(negedge CLK);
        sel_g = sel;
        drive(sel, 1'b1, fun, a, b);
        @(posedge CLK);
        #1;
        drive(sel, pulse, 4'($urandom), 16'($urandom), 16'($urandom));
        check("busy_after_accept", 32'(m_busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 64) begin
            @(posedge CLK);
            cyc++;
            #1;
            if (cyc == 1) drive(sel, 1'b0, 4'($urandom), 16'($urandom), 16'($urandom));
            if (m_flag === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        if (!seen) begin
            check("flag_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(cyc), 32'(e.lat));
            check("result", 32'(m_out), 32'(e.out));
            check("carry", 32'(m_carry), 32'(e.carry));
            check("err", 32'(m_err), 32'(e.err));
            check("busy_at_flag", 32'(m_busy), 32'd0);
            extra = 0;
            repeat (pulse ? 6 : 1) begin
                @(posedge CLK);
                #1;
                if (m_flag !== 1'b0) extra++;
            end
            check("flag_single", 32'(extra), 32'd0);
            check("result_held", 32'(m_out), 32'(e.out));
        end
    endtask

    initial begin
        int nflag;
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
        RST = 1'b1;

        // Reset with random stimulus on the inputs.
        nflag = 0;
        repeat (2) begin
            @(negedge CLK);
            drive(1'b0, 1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
            drive(1'b1, 1'($urandom), 4'($urandom), 16'($urandom), 16'($urandom));
            @(posedge CLK);
            #1;
            if (bus1.Shift_Flag !== 1'b0 || bus4.Shift_Flag !== 1'b0) nflag++;
        end
        check("rst_no_flag", 32'(nflag), 32'd0);
        check("rst_out", 32'(bus1.Shift_OUT), 32'd0);
        check("rst_carry", 32'(bus1.Carry_OUT), 32'd0);
        check("rst_err", 32'(bus1.Shift_Err), 32'd0);
        check("rst_busy", 32'(bus1.Busy), 32'd0);
        check("rst_out4", 32'(bus4.Shift_OUT), 32'd0);
        check("rst_busy4", 32'(bus4.Busy), 32'd0);
        @(negedge CLK);
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 4'd0, 16'd0, 16'd0);
        RST = 1'b0;

        run_op(1'b0, 4'b0000, 16'h8001, 16'h0001, 1'b0);   // SRL
        run_op(1'b0, 4'b0010, 16'h8000, 16'h0004, 1'b1);   // SRA with busy pulse
        run_op(1'b0, 4'b0100, 16'h8001, 16'h0004, 1'b0);   // ROL
        run_op(1'b0, 4'b0001, 16'h1234, 16'h0000, 1'b0);   // amt 0
        run_op(1'b0, 4'b0101, 16'hFFFF, 16'h0003, 1'b0);   // illegal
        run_op(1'b0, 4'b1011, 16'h00F1, 16'hFFF3, 1'b0);   // ROR, upper bits ignored
        run_op(1'b0, 4'b0001, 16'hA5A5, 16'h000F, 1'b0);   // SLL max amount

        // Abort mid-operation with reset.
        @(negedge CLK);
        sel_g = 1'b0;
        drive(1'b0, 1'b1, 4'b0001, 16'h00FF, 16'h0008);
        @(posedge CLK);
        #1;
        drive(1'b0, 1'b0, 4'd0, 16'd0, 16'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_out", 32'(bus1.Shift_OUT), 32'd0);
        check("abort_busy", 32'(bus1.Busy), 32'd0);
        check("abort_err", 32'(bus1.Shift_Err), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        nflag = 0;
        repeat (12) begin
            @(posedge CLK);
            #1;
            if (bus1.Shift_Flag !== 1'b0) nflag++;
        end
        check("abort_no_flag", 32'(nflag), 32'd0);

        run_op(1'b1, 4'b0001, 16'h0001, 16'h0005, 1'b0);   // STEP=4, N=3
        run_op(1'b1, 4'b0011, 16'h1234, 16'h000F, 1'b1);   // STEP=4, ROR 15
        run_op(1'b1, 4'b0110, 16'h1234, 16'h0002, 1'b0);   // STEP=4, illegal

        for (int i = 0; i < 24; i++) begin
            run_op(1'(i % 2), 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
Parametrised multi-cycle shifter/rotator for the ALU datapath. It takes a shift amount and mode per operation instead of fixed shift-by-1.
- Shifts STEP bit positions per clock under a 3-state FSM.
- Start/busy/done handshake to the ALU controller.
- Registered result, carry-out and error flag.
- Sits beside the arithmetic and logic units; its result is muxed onto the ALU output bus.

Parameters:
- WIDTH, 16, data width; must be a power of 2, minimum 4.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount field.
- STEP, 1, positions shifted per SHIFT cycle; range 1..WIDTH-1.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- A  in  WIDTH  operand to shift.
- B  in  WIDTH  B[SHAMT_W-1:0] = shift amount; upper bits ignored.
- ALU_FUN  in  4  ALU_FUN[2:0] = mode; ALU_FUN[3] ignored.
- Shift_Enable  in  1  start request; sampled only in IDLE.
- Shift_OUT  out  WIDTH  registered result; held until next completion.
- Shift_Flag  out  1  done strobe, high exactly 1 cycle.
- Carry_OUT  out  1  last bit shifted/rotated out; valid with Shift_Flag, then held.
- Shift_Err  out  1  illegal mode; valid with Shift_Flag, then held.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: one clock, synchronous and active-high, is fixed for this block. While RST=1 at a CLK edge:
  - state <= IDLE.
  - Shift_OUT, Carry_OUT, Shift_Err, Shift_Flag, Busy all <= 0.
  - Internal work register, remaining count, latched mode <= 0.
  - RST overrides everything, including mid-operation; the aborted op produces no Shift_Flag.
- Modes (ALU_FUN[2:0]):
  - 000 SRL, logical right.
  - 001 SLL, logical left.
  - 010 SRA, arithmetic right, MSB replicated.
  - 011 ROR, rotate right.
  - 100 ROL, rotate left.
  - 101..111 illegal.
- Amounts are 0..WIDTH-1. Larger values are impossible (masked by SHAMT_W).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If Shift_Enable=1: latch A into the work register, amt=B[SHAMT_W-1:0] into remaining, and the mode.
  - Go to DONE if amt==0 or mode illegal; else go to SHIFT.
  - If Shift_Enable=0: stay in IDLE; all outputs hold.
- SHIFT:
  - Each cycle apply k=min(STEP, remaining) positions and decrement remaining by k.
  - Track carry as the last bit leaving the register. For rotates this is the bit that wrapped.
  - When remaining reaches 0 after the update, go to DONE.
- DONE:
  - On entry, register Shift_OUT, Carry_OUT and Shift_Err, and set Shift_Flag=1.
  - Always go to IDLE the next cycle; Shift_Flag drops.
  - Illegal mode: Shift_OUT=0, Carry_OUT=0, Shift_Err=1.
  - amt==0: Shift_OUT=A, Carry_OUT=0, Shift_Err=0.
- Latency: with the accepting edge at t0, Shift_Flag is high in the cycle after edge t0+N, where N = 1 + ceil(amt/STEP). amt=0 or illegal mode gives N=1.
- Shift_Enable while Busy=1 (SHIFT or DONE) is ignored and not queued. Earliest back-to-back start is the first IDLE cycle after the DONE cycle.
- A and B may change freely after the accepting edge; operands are latched.
- Width rules:
  - The remaining counter is SHAMT_W bits.
  - The work register is WIDTH bits.
  - No intermediate wider than WIDTH+1 is needed.

Optional Feature:
- Macro: SHIFT_UNIT_SEQ_BARREL_EN.
- Defined:
  - SHIFT state and counter are not synthesised; STEP is ignored.
  - A single-cycle barrel shifter computes the full result.
  - IDLE with Shift_Enable goes directly to DONE, so N=1 for all amounts and modes.
  - Busy is high only in DONE.
  - Result, carry and Err semantics are identical to the serial build.
- Undefined: serial behaviour as specified above.

Test Plan:
- (WIDTH=16, STEP=1) Reset: RST=1 for 2 cycles with random inputs -> all outputs 0, Busy=0, no Shift_Flag.
- SRL, A=0x8001, amt=1 -> Shift_Flag 2 cycles after accept; Shift_OUT=0x4000, Carry_OUT=1, Shift_Err=0.
- SRA, A=0x8000, amt=4 -> N=5; Shift_OUT=0xF800, Carry_OUT=0.
  - Shift_Enable pulsed while Busy is ignored; exactly one Shift_Flag.
- ROL, A=0x8001, amt=4 -> Shift_OUT=0x0018, Carry_OUT=0.
- amt=0 with SLL, A=0x1234 -> N=1, Shift_OUT=0x1234, Carry_OUT=0.
  - ALU_FUN=0101 -> N=1, Shift_OUT=0, Shift_Err=1.
- Reset mid-op and STEP variant:
  - RST=1 during SHIFT of amt=8 -> IDLE, outputs 0, no Shift_Flag.
  - STEP=4, SLL, A=0x0001, amt=5 -> N=3, Shift_OUT=0x0020.
  - With SHIFT_UNIT_SEQ_BARREL_EN defined, the same op gives N=1.
